// File: rtl/hdb3_decoder.sv
// HDB3 line decoder: strips bipolar violations and their substitution pulse, restoring NRZ bits.
// Latency: symbol k is presented the cycle after symbol k+4 is accepted (4-symbol window).
// Backpressure: none; the stream is paced by in_valid, and idle cycles hold all state.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset
//   in_valid   data_hdb3 carries a symbol this cycle
//   data_hdb3  2'b00 = 0, 2'b01 = +1, 2'b10 = -1, 2'b11 = illegal
//   data_out   decoded NRZ bit, qualified by out_valid
//   out_valid  registered valid for data_out
//   code_err   one-cycle pulse for an error on the symbol accepted last cycle
//   err_count  saturating count of code_err pulses
module hdb3_decoder #(
  parameter int ERR_CNT_W = 16,
  parameter bit CHECK_EN  = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [1:0]           data_hdb3,
  output logic                 data_out,
  output logic                 out_valid,
  output logic                 code_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam logic [1:0] SYM_POS = 2'b01;
  localparam logic [1:0] SYM_NEG = 2'b10;
  localparam logic [1:0] SYM_ILL = 2'b11;
  localparam logic [ERR_CNT_W-1:0] CNT_ONE = {{(ERR_CNT_W-1){1'b0}}, 1'b1};

  // sr[0] holds the newest mark, sr[3] the oldest (next to be emitted)
  logic [3:0] sr;
  logic [2:0] fill;
  logic       first_seen;
  logic       last_pol;     // 1 = last normal pulse was negative

  logic is_pulse;
  logic pol;
  logic is_illegal;
  logic is_v;
  logic mark;
  logic v_err;
  logic err_next;
  logic [3:0] sr_next;

  always_comb begin
    is_pulse   = (data_hdb3 == SYM_POS) || (data_hdb3 == SYM_NEG);
    pol        = (data_hdb3 == SYM_NEG);
    is_illegal = (data_hdb3 == SYM_ILL);
    // A repeat of the previous pulse polarity is a violation
    is_v       = is_pulse && first_seen && (pol == last_pol);
    mark       = is_pulse && !is_v;
    // A well-formed substitution has only zeros between the B/0 slot and the V
    v_err      = CHECK_EN && is_v && (sr[0] || sr[1]);
    err_next   = is_illegal || v_err;
    // The V also removes the B (or leading 0) three symbols back as it moves to the output slot
    sr_next    = {(is_v ? 1'b0 : sr[2]), sr[1], sr[0], mark};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sr         <= 4'b0000;
      fill       <= 3'd0;
      first_seen <= 1'b0;
      last_pol   <= 1'b0;
      data_out   <= 1'b0;
      out_valid  <= 1'b0;
      code_err   <= 1'b0;
      err_count  <= '0;
    end else if (in_valid) begin
      sr       <= sr_next;
      code_err <= err_next;
      if (err_next && (err_count != {ERR_CNT_W{1'b1}})) begin
        err_count <= err_count + CNT_ONE;
      end
      if (mark) begin
        last_pol   <= pol;
        first_seen <= 1'b1;
      end
      if (fill == 3'd4) begin
        data_out  <= sr[3];
        out_valid <= 1'b1;
      end else begin
        out_valid <= 1'b0;
        fill      <= fill + 3'd1;
      end
    end else begin
      out_valid <= 1'b0;
      code_err  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_hdb3_decoder.sv
module tb_hdb3_decoder;

  localparam logic [1:0] Z = 2'b00;
  localparam logic [1:0] P = 2'b01;
  localparam logic [1:0] N = 2'b10;
  localparam logic [1:0] X = 2'b11;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic [1:0] data_hdb3 = 2'b00;

  logic        d1_out, d1_ov, d1_err;
  logic [15:0] d1_cnt;
  logic        d0_out, d0_ov, d0_err;
  logic [2:0]  d0_cnt;

  always #5 clk = ~clk;

  hdb3_decoder #(.ERR_CNT_W(16), .CHECK_EN(1'b1)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .data_hdb3(data_hdb3),
    .data_out(d1_out), .out_valid(d1_ov), .code_err(d1_err), .err_count(d1_cnt)
  );

  hdb3_decoder #(.ERR_CNT_W(3), .CHECK_EN(1'b0)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .data_hdb3(data_hdb3),
    .data_out(d0_out), .out_valid(d0_ov), .code_err(d0_err), .err_count(d0_cnt)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: whole symbol history since the last reset
  logic [1:0] syms[$];
  bit         marks[$];
  bit e_ov, e_dout, e_dchk, e_err1, e_err0;
  int e_cnt1, e_cnt0;
  bit live = 1'b0;

  task automatic model_reset();
    syms.delete();
    marks.delete();
    e_ov = 0; e_dout = 0; e_dchk = 1; e_err1 = 0; e_err0 = 0;
    e_cnt1 = 0; e_cnt0 = 0;
  endtask

  task automatic model_idle();
    e_ov = 0; e_dchk = 0; e_err1 = 0; e_err0 = 0;
  endtask

  task automatic model_accept(input logic [1:0] code);
    int  i;
    bit  is_v, pulse, illegal, near;
    i       = syms.size();
    pulse   = (code == P) || (code == N);
    illegal = (code == X);
    is_v    = 0;
    if (pulse) begin
      // violation = same polarity as the most recent pulse of any kind
      for (int j = i - 1; j >= 0; j--) begin
        if (syms[j] == P || syms[j] == N) begin
          is_v = (syms[j] == code);
          break;
        end
      end
    end
    near = 0;
    if (i >= 1 && marks[i-1]) near = 1;
    if (i >= 2 && marks[i-2]) near = 1;
    e_err0 = illegal;
    e_err1 = illegal || (is_v && near);
    if (is_v && i >= 3) marks[i-3] = 0;
    syms.push_back(code);
    marks.push_back(pulse && !is_v);
    e_ov   = (i >= 4);
    e_dchk = e_ov;
    if (e_ov) e_dout = marks[i-4];
    if (e_err1 && e_cnt1 < 65535) e_cnt1++;
    if (e_err0 && e_cnt0 < 7) e_cnt0++;
  endtask

  // Per-cycle comparison against the model
  always @(posedge clk) begin
    if (live) begin
      #1;
      chk("ov1", d1_ov, e_ov);
      chk("err1", d1_err, e_err1);
      chk("cnt1", d1_cnt, e_cnt1);
      chk("ov0", d0_ov, e_ov);
      chk("err0", d0_err, e_err0);
      chk("cnt0", int'(d0_cnt), e_cnt0);
      if (e_dchk) begin
        chk("dout1", d1_out, e_dout);
        chk("dout0", d0_out, e_dout);
      end
    end
  end

  // Capture of decoded bits for the literal checks
  bit cap[$];
  always @(posedge clk) begin
    #1;
    if (d1_ov) cap.push_back(d1_out);
  end

  task automatic do_reset();
    @(negedge clk);
    reset     = 1'b1;
    in_valid  = 1'($urandom_range(0, 1));
    data_hdb3 = 2'($urandom_range(0, 3));
    model_reset();
    cap.delete();
    live = 1'b1;
  endtask

  task automatic step(input bit v, input logic [1:0] code);
    @(negedge clk);
    reset    = 1'b0;
    in_valid = v;
    if (v) begin
      data_hdb3 = code;
      model_accept(code);
    end else begin
      data_hdb3 = 2'($urandom_range(0, 3));
      model_idle();
    end
  endtask

  task automatic send_seq(input logic [1:0] codes[$], input int gap);
    foreach (codes[k]) begin
      step(1'b1, codes[k]);
      for (int g = 0; g < gap; g++) step(1'b0, Z);
    end
    step(1'b0, Z);
  endtask

  // bits is read MSB-first within its low n bits: first output is bits[n-1]
  task automatic chk_cap(input string name, input int n, input logic [7:0] bits);
    logic [7:0] act;
    act = '0;
    chk({name, "_len"}, cap.size(), n);
    foreach (cap[k]) act = {act[6:0], cap[k]};
    chk({name, "_bits"}, act, bits);
  endtask

  initial begin
    logic [1:0] code;
    int r;

    // Reset state
    do_reset();
    step(1'b0, Z);
    chk("rst_cnt", d1_cnt, 0);

    // Alternating marks
    do_reset();
    send_seq('{P, N, P, N, P, N}, 0);
    chk_cap("t1", 2, 8'b11);
    chk("t1_cnt", d1_cnt, 0);

    // 000V substitution
    do_reset();
    send_seq('{P, Z, Z, Z, P, N}, 0);
    chk_cap("t2", 2, 8'b10);
    chk("t2_cnt", d1_cnt, 0);

    // B00V substitution
    do_reset();
    send_seq('{P, N, Z, Z, N, P, N, P, N}, 0);
    chk_cap("t3", 5, 8'b10000);

    // Illegal code decodes as 0 and does not touch polarity history
    do_reset();
    send_seq('{P, N, X, P, N, Z, Z, Z}, 0);
    chk_cap("t4", 4, 8'b1101);
    chk("t4_cnt", d1_cnt, 1);

    // Malformed violation: flagged only with checking enabled
    do_reset();
    send_seq('{P, Z, N, Z, N}, 0);
    chk("t5_cnt1", d1_cnt, 1);
    chk("t5_cnt0", int'(d0_cnt), 0);

    // Idle gaps do not change the decoded stream
    do_reset();
    send_seq('{P, N, Z, Z, N, P, N, P, N}, 3);
    chk_cap("t6", 5, 8'b10000);

    // Reset mid-stream discards buffered symbols
    do_reset();
    send_seq('{P, N, P, N, P, N}, 0);
    do_reset();
    send_seq('{N, Z, Z, Z}, 3);
    chk_cap("t6r_empty", 0, 8'b0);
    send_seq('{P}, 0);
    chk_cap("t6r_one", 1, 8'b1);

    // Randomized stream with occasional resets
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        r = $urandom_range(0, 15);
        code = (r == 0) ? X : (r < 7) ? Z : (r < 12) ? P : N;
        step($urandom_range(0, 3) != 0, code);
      end
    end
    step(1'b0, Z);
    step(1'b0, Z);
    live = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
